fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch buffer, replacing the single-register PC/IF stage of the 5-stage pipeline. It generates sequential fetch addresses, issues them to an instruction memory with a request/grant and in-order response handshake, buffers returned words in a DEPTH-entry queue, and presents them with their PC to the IF/ID register under a valid/ready handshake. Branch/jump redirects from ID flush the queue and discard in-flight responses.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 138 +++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and helpers for the instruction-fetch front end.
package fetch_queue_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Sequential instruction stride in bytes.
  localparam int unsigned PC_STEP = 4;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH x XLEN ring buffer with push/pop/flush, occupancy count
// and full/empty flags. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = cnt_width(DEPTH),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

  // A push into a full ring is only accepted when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with prefetch queue.
// Issues sequential fetches under a credit limit (queued + outstanding < DEPTH),
// buffers in-order responses, and hands words with their PC to IF/ID.
// Redirects flush the queue and discard responses still in flight.
// Optional: define FETCH_QUEUE_BYPASS_EN to forward a response straight to the
// output in the same cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pcadd4
);

  localparam int unsigned     CW   = cnt_width(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  // One extra bit: the issue credit ignores drop, so back-to-back redirects
  // can leave more than DEPTH responses waiting to be discarded.
  logic [CW:0]     drop_q, drop_d;

  logic [XLEN-1:0] q_rdata;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;

  logic [CW:0]     inflight;
  logic            req;
  logic            gnt_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            head_valid;
  logic [XLEN-1:0] head_data;
  logic            deq_fire;
  logic [XLEN-1:0] pc_out;

  fetch_queue_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redir_valid),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i (imem_rdata),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign inflight = {1'b0, q_count} + {1'b0, outst_q};
  assign req      = reset && !redir_valid && !q_full && (inflight < (CW+1)'(DEPTH));
  assign gnt_fire = req && imem_gnt;
  assign rsp_keep = imem_rvalid && (drop_q == '0);
  assign rsp_drop = imem_rvalid && (drop_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp        = q_empty && !redir_valid && rsp_keep;
  assign head_valid = !q_empty || byp;
  assign head_data  = q_empty ? imem_rdata : q_rdata;
  assign q_push     = rsp_keep && !redir_valid && !(byp && inst_ready);
`else
  assign head_valid = !q_empty;
  assign head_data  = q_rdata;
  assign q_push     = rsp_keep && !redir_valid;
`endif

  assign q_pop    = !q_empty && inst_ready && !redir_valid;
  assign deq_fire = head_valid && inst_ready && !redir_valid;

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = reset && head_valid;
  assign inst        = reset ? head_data : '0;
  assign pc_out      = reset ? head_pc_q : '0;
  assign inst_pc     = pc_out;
  assign inst_pcadd4 = pc_out + STEP;

  // Next-state for PCs and request counters; a redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redir_valid) begin
      fetch_pc_d = redir_pc;
      head_pc_d  = redir_pc;
      outst_d    = '0;
      // Whichever counter this cycle's response retires, the total still
      // waiting on the memory is drop + outst - 1.
      drop_d     = drop_q + (CW+1)'(outst_q) - (CW+1)'(imem_rvalid);
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (deq_fire) head_pc_d  = head_pc_q + STEP;
      outst_d = outst_q + CW'(gnt_fire) - CW'(rsp_keep);
      drop_d  = drop_q - (CW+1)'(rsp_drop);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a latency-programmable
// in-order memory model that returns the request address as data.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcadd4;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;
  int grants = 0;
  logic [31:0] mq_addr [$];
  int          mq_due [$];

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = 1;
`endif

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pcadd4 (inst_pcadd4)
  );

  always #5 clk = ~clk;

  // Memory model: record grants mid-cycle, return responses lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset && mq_due.size() > 0 && mq_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq_addr.pop_front();
        void'(mq_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    look();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_inst", inst, 0);

    // Streaming with 1-cycle memory
    tick();
    reset = 1'b1;
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      look();
      chk("t1_req", 32'(imem_req), 1);
      chk("t1_addr", imem_addr, 32'h0040_0000 + 4 * k);
      if (k >= 1 + FIRST) begin
        chk("t1_valid", 32'(inst_valid), 1);
        chk("t1_pc", inst_pc, 32'h0040_0000 + 4 * (k - 1 - FIRST));
        chk("t1_inst", inst, 32'h0040_0000 + 4 * (k - 1 - FIRST));
        chk("t1_pcadd4", inst_pcadd4, 32'h0040_0004 + 4 * (k - 1 - FIRST));
      end else begin
        chk("t1_valid_lat", 32'(inst_valid), 0);
      end
    end

    // Redirect while stalled: queue fills to exactly DEPTH
    tick();
    redir_valid = 1'b1;
    redir_pc = 32'h0040_0200;
    inst_ready = 1'b0;
    look();
    chk("t2_redir_noreq", 32'(imem_req), 0);
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) redir_valid = 1'b0;
      look();
      if (imem_req && imem_gnt) grants++;
    end
    chk("t2_grants", 32'(grants), 4);
    chk("t2_full_noreq", 32'(imem_req), 0);
    chk("t2_valid", 32'(inst_valid), 1);
    chk("t2_pc", inst_pc, 32'h0040_0200);
    chk("t2_inst", inst, 32'h0040_0200);
    tick();
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      look();
      chk("t2_resume_valid", 32'(inst_valid), 1);
      chk("t2_resume_pc", inst_pc, 32'h0040_0200 + 4 * k);
      chk("t2_resume_inst", inst, 32'h0040_0200 + 4 * k);
    end

    // Drain, then redirect with 3 requests outstanding (latency 4)
    tick();
    imem_gnt = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    look();
    chk("t3_drained", 32'(inst_valid), 0);
    tick();
    lat = 4;
    imem_gnt = 1'b1;
    tick();
    tick();
    tick();
    imem_gnt = 1'b0;
    redir_valid = 1'b1;
    redir_pc = 32'h0040_0100;
    look();
    chk("t3_outst", 32'(mq_addr.size()), 3);
    chk("t3_redir_noreq", 32'(imem_req), 0);
    tick();
    redir_valid = 1'b0;
    imem_gnt = 1'b1;
    for (int j = 0; j <= 4 + FIRST; j++) begin
      if (j > 0) tick();
      look();
      if (j == 0) chk("t3_newaddr", imem_addr, 32'h0040_0100);
      if (j < 4 + FIRST) begin
        chk("t3_discard", 32'(inst_valid), 0);
      end else begin
        chk("t3_valid", 32'(inst_valid), 1);
        chk("t3_pc", inst_pc, 32'h0040_0100);
        chk("t3_inst", inst, 32'h0040_0100);
      end
    end

    // Redirect coinciding with a response and a ready consumer (latency 2)
    tick();
    lat = 2;
    for (int k = 0; k < 12; k++) tick();
    redir_valid = 1'b1;
    redir_pc = 32'h0040_0400;
    look();
    chk("t4_rvalid_same", 32'(imem_rvalid), 1);
    tick();
    redir_valid = 1'b0;
    for (int j = 0; j <= 2 + FIRST; j++) begin
      if (j > 0) tick();
      look();
      if (j == 0) begin
        chk("t4_req", 32'(imem_req), 1);
        chk("t4_addr", imem_addr, 32'h0040_0400);
      end
      if (j < 2 + FIRST) begin
        chk("t4_empty", 32'(inst_valid), 0);
      end else begin
        chk("t4_valid", 32'(inst_valid), 1);
        chk("t4_pc", inst_pc, 32'h0040_0400);
        chk("t4_inst", inst, 32'h0040_0400);
      end
    end

    // Reset pulse mid-stream with a partly filled queue
    tick();
    lat = 1;
    for (int k = 0; k < 4; k++) tick();
    inst_ready = 1'b0;
    tick();
    tick();
    look();
    chk("t5_pre_valid", 32'(inst_valid), 1);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(inst_valid), 0);
    chk("t5_rst_req", 32'(imem_req), 0);
    chk("t5_rst_pc", inst_pc, 0);
    tick();
    tick();
    reset = 1'b1;
    inst_ready = 1'b1;
    for (int k = 0; k <= 1 + FIRST; k++) begin
      if (k > 0) tick();
      look();
      if (k == 0) begin
        chk("t5_req", 32'(imem_req), 1);
        chk("t5_addr", imem_addr, 32'h0040_0000);
      end
      if (k < 1 + FIRST) begin
        chk("t5_lat", 32'(inst_valid), 0);
      end else begin
        chk("t5_valid", 32'(inst_valid), 1);
        chk("t5_pc", inst_pc, 32'h0040_0000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
